// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer.
//
// Runs a fixed program IDLE -> FILL -> WASH -> DRAIN -> SPIN -> DONE. The program is paced by a
// 1 s tick that comes from a clock prescaler. A pause pulse freezes the running phase, and
// abort drains the drum and returns to IDLE. After completion a buzzer window runs and then
// overtime ticks are counted until ack.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   start         pulse: begin the program selected by mode (IDLE only, mode < MODES)
//   pause         pulse: toggle pause in FILL/WASH/DRAIN/SPIN
//   abort         pulse: cancel the program (drain first if there is water)
//   ack           pulse: acknowledge completion in DONE
//   mode          program select, sampled only with an accepted start
//   st_light      {aborted, PAUSE, DONE, SPIN, DRAIN, WASH, FILL, IDLE} lamps
//   water         thermometer water level, LSB-first
//   remain        ticks left in WASH or SPIN, else 0
//   busy / done   state != IDLE / state == DONE
//   buzzer        completion alert for the first BUZZ_T ticks of DONE
//   overtime      saturating count of ticks spent in DONE after the buzzer window
module wash_sequencer #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned MODES     = 4,
  parameter int unsigned WL        = 8,
  parameter int unsigned TW        = 8,
  parameter int unsigned WASH_BASE = 6,
  parameter int unsigned WASH_STEP = 3,
  parameter int unsigned SPIN_T    = 4,
  parameter int unsigned BUZZ_T    = 3,
  localparam int unsigned MW       = (MODES > 1) ? $clog2(MODES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic          ack,
  input  logic [MW-1:0] mode,
  output logic [7:0]    st_light,
  output logic [WL-1:0] water,
  output logic [TW-1:0] remain,
  output logic          busy,
  output logic          done,
  output logic          buzzer,
  output logic [TW-1:0] overtime
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BUZZ_T > 0) ? $clog2(BUZZ_T + 1) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StFill, StWash, StDrain, StSpin, StDone, StPause
  } state_e;

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [WL-1:0] water_q, water_d;
  logic [TW-1:0] remain_q, remain_d;
  logic [MW-1:0] mode_q, mode_d;
  logic          aborted_q, aborted_d;
  logic [TW-1:0] overtime_q, overtime_d;
  logic          buzzer_q, buzzer_d;
  logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic          active;
  logic          tick;

  function automatic int unsigned ones(input logic [WL-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(WL); i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  function automatic int unsigned fill_target(input logic [MW-1:0] m);
    int unsigned t;
    t = ((32'(m) + 1) * WL) / MODES;
    if (t < 1) t = 1;
    return t;
  endfunction

  function automatic logic [7:0] lamp(input state_e s);
    logic [7:0] l;
    case (s)
      StIdle:  l = 8'h01;
      StFill:  l = 8'h02;
      StWash:  l = 8'h04;
      StDrain: l = 8'h08;
      StSpin:  l = 8'h10;
      StDone:  l = 8'h20;
      StPause: l = 8'h40;
      default: l = 8'h00;
    endcase
    return l;
  endfunction

  // The prescaler only runs in phases that consume ticks; PAUSE leaves it frozen.
  assign active = state_q inside {StFill, StWash, StDrain, StSpin, StDone};
  assign tick   = active && (presc_q == PrescMax);

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    presc_d    = presc_q;
    water_d    = water_q;
    remain_d   = remain_q;
    mode_d     = mode_q;
    aborted_d  = aborted_q;
    overtime_d = overtime_q;
    buzzer_d   = buzzer_q;
    buzz_cnt_d = buzz_cnt_q;

    // Tick-driven transitions land with presc_d already wrapped to 0, which gives every phase
    // a full tick period after entry.
    if (active) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end else if (state_q == StIdle) begin
      presc_d = '0;
    end

    if (abort && (state_q inside {StFill, StWash, StSpin, StPause})) begin
      aborted_d = 1'b1;
      remain_d  = '0;
      presc_d   = '0;
      state_d   = (water_q == '0) ? StIdle : StDrain;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && (32'(mode) < MODES)) begin
            mode_d     = mode;
            overtime_d = '0;
            aborted_d  = 1'b0;
            state_d    = StFill;
          end
        end
        StFill, StWash, StDrain, StSpin: begin
          if (abort) begin
            // Only reachable in DRAIN: flag the abort and defer any coincident tick a cycle.
            aborted_d = 1'b1;
            presc_d   = presc_q;
          end else if (pause) begin
            ret_d   = state_q;
            state_d = StPause;
            presc_d = presc_q;
          end else if (tick) begin
            case (state_q)
              StFill: begin
                water_d = (water_q << 1) | WL'(1);
                if (ones(water_q) + 1 >= fill_target(mode_q)) begin
                  state_d  = StWash;
                  remain_d = TW'(WASH_BASE + 32'(mode_q) * WASH_STEP);
                end
              end
              StWash, StSpin: begin
                if (remain_q <= TW'(1)) begin
                  remain_d = '0;
                  if (state_q == StWash) begin
                    state_d = StDrain;
                  end else begin
                    state_d    = StDone;
                    buzzer_d   = (BUZZ_T != 0);
                    buzz_cnt_d = '0;
                  end
                end else begin
                  remain_d = remain_q - 1'b1;
                end
              end
              StDrain: begin
                // The level is a thermometer code, so a right shift clears its top bit.
                water_d = water_q >> 1;
                if ((water_q >> 1) == '0) begin
                  if (aborted_q) begin
                    state_d = StIdle;
                  end else begin
                    state_d  = StSpin;
                    remain_d = TW'(SPIN_T);
                  end
                end
              end
              default: ;
            endcase
          end
        end
        StDone: begin
          if (ack) begin
            state_d    = StIdle;
            buzzer_d   = 1'b0;
            buzz_cnt_d = '0;
            presc_d    = '0;
          end else if (tick) begin
            if (buzzer_q) begin
              buzz_cnt_d = buzz_cnt_q + 1'b1;
              if (32'(buzz_cnt_q) + 1 >= BUZZ_T) buzzer_d = 1'b0;
            end else if (overtime_q != '1) begin
              overtime_d = overtime_q + 1'b1;
            end
          end
        end
        StPause: begin
          if (pause) state_d = ret_q;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ret_q      <= StIdle;
      presc_q    <= '0;
      water_q    <= '0;
      remain_q   <= '0;
      mode_q     <= '0;
      aborted_q  <= 1'b0;
      overtime_q <= '0;
      buzzer_q   <= 1'b0;
      buzz_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      presc_q    <= presc_d;
      water_q    <= water_d;
      remain_q   <= remain_d;
      mode_q     <= mode_d;
      aborted_q  <= aborted_d;
      overtime_q <= overtime_d;
      buzzer_q   <= buzzer_d;
      buzz_cnt_q <= buzz_cnt_d;
    end
  end

  // While paused the frozen phase lamp stays lit next to the PAUSE lamp.
  assign st_light = lamp(state_q) | ((state_q == StPause) ? lamp(ret_q) : 8'h00)
                  | {aborted_q, 7'b0};
  assign water    = water_q;
  assign remain   = remain_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign buzzer   = buzzer_q;
  assign overtime = overtime_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer. A timeline model derives the phase, water level and
// remaining ticks from elapsed cycles; pauses shift that timeline by hold+1 cycles.
module tb_wash_sequencer;

  localparam int TD = 4;
  localparam int NM = 4;
  localparam int WB = 6;
  localparam int WS = 3;
  localparam int ST = 4;
  localparam int BT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, pause = 1'b0, abort = 1'b0, ack = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] st_light;
  logic [7:0] water, remain, overtime;
  logic       busy, done, buzzer;

  logic       start3 = 1'b0, zero = 1'b0;
  logic [1:0] mode3 = 2'd0;
  logic [7:0] st_light3, water3, remain3, overtime3;
  logic       busy3, done3, buzzer3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wash_sequencer #(
    .TICK_DIV(TD), .MODES(NM), .WL(8), .TW(8),
    .WASH_BASE(WB), .WASH_STEP(WS), .SPIN_T(ST), .BUZZ_T(BT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort), .ack(ack),
    .mode(mode), .st_light(st_light), .water(water), .remain(remain), .busy(busy),
    .done(done), .buzzer(buzzer), .overtime(overtime)
  );

  wash_sequencer #(
    .TICK_DIV(TD), .MODES(3), .WL(8), .TW(8),
    .WASH_BASE(WB), .WASH_STEP(WS), .SPIN_T(ST), .BUZZ_T(BT)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start3), .pause(zero), .abort(zero), .ack(zero),
    .mode(mode3), .st_light(st_light3), .water(water3), .remain(remain3), .busy(busy3),
    .done(done3), .buzzer(buzzer3), .overtime(overtime3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int target(input int m, input int modes);
    int t;
    t = ((m + 1) * 8) / modes;
    if (t < 1) t = 1;
    return t;
  endfunction

  function automatic logic [7:0] therm(input int n);
    return 8'((32'd1 << n) - 1);
  endfunction

  // Phase (1 FILL .. 5 DONE), remain and water count c cycles after the start edge.
  task automatic model_at(input int m, input int c, output int ph, output int rem,
                          output int wc);
    int tg, ws, f_end, w_end, d_end, s_end;
    tg    = target(m, NM);
    ws    = (WB + m * WS) % 256;
    f_end = tg * TD;
    w_end = f_end + ws * TD;
    d_end = w_end + tg * TD;
    s_end = d_end + ST * TD;
    if (c < f_end) begin
      ph = 1; rem = 0; wc = c / TD;
    end else if (c < w_end) begin
      ph = 2; rem = ws - (c - f_end) / TD; wc = tg;
    end else if (c < d_end) begin
      ph = 3; rem = 0; wc = tg - (c - w_end) / TD;
    end else if (c < s_end) begin
      ph = 4; rem = ST - (c - d_end) / TD; wc = 0;
    end else begin
      ph = 5; rem = 0; wc = 0;
    end
  endtask

  function automatic int prog_len(input int m);
    return (2 * target(m, NM) + (WB + m * WS) % 256 + ST) * TD;
  endfunction

  task automatic chk_trace(input int m, input int c, input bit paused, input string tag);
    int ph, rem, wc;
    model_at(m, c, ph, rem, wc);
    chk(tag, {st_light, water, remain, busy, done, buzzer, overtime},
        {8'(1 << ph) | (paused ? 8'h40 : 8'h00), therm(wc), 8'(rem), 1'b1, (ph == 5),
         (ph == 5), 8'h00});
  endtask

  // Full program; p != 0 pauses at edge p and resumes at edge p+hold.
  task automatic run(input int m, input int p, input int hold, input int linger);
    int e, c, bz, ot;
    bit paused;
    mode = 2'(m);
    start = 1'b1;
    step();
    start = 1'b0;
    mode = 2'(3 - m);
    e = prog_len(m) + ((p != 0) ? hold + 1 : 0);
    for (int k = 0; k <= e; k++) begin
      if (p != 0 && k >= p && k < p + hold) begin
        c = p - 1; paused = 1'b1;
      end else if (p != 0 && k >= p + hold) begin
        c = k - hold - 1; paused = 1'b0;
      end else begin
        c = k; paused = 1'b0;
      end
      chk_trace(m, c, paused, "trace");
      if (k < e) begin
        pause = (p != 0) && (k + 1 == p || k + 1 == p + hold);
        start = (k + 1 == 6);
        step();
        pause = 1'b0;
        start = 1'b0;
      end
    end
    bz = 0;
    for (int j = 0; j < linger; j++) begin
      if (buzzer) bz++;
      step();
    end
    ot = linger / TD - BT;
    if (ot < 0) ot = 0;
    if (ot > 255) ot = 255;
    chk("buzz_cycles", bz, BT * TD);
    chk("overtime", overtime, ot);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_idle", {st_light, busy, done, buzzer}, {8'h01, 3'b000});
    chk("ot_hold", overtime, ot);
  endtask

  // Abort sampled at edge c+1, optionally together with pause.
  task automatic run_abort(input int m, input int c, input bit pz);
    int ph, rem, wc;
    bit seen_spin, seen_pause;
    mode = 2'(m);
    start = 1'b1;
    step();
    start = 1'b0;
    mode = 2'(3 - m);
    for (int k = 0; k <= c; k++) begin
      chk_trace(m, k, 1'b0, "pre_abort");
      if (k < c) step();
    end
    model_at(m, c, ph, rem, wc);
    abort = 1'b1;
    pause = pz;
    step();
    abort = 1'b0;
    pause = 1'b0;
    chk("abort_light", st_light, (wc > 0) ? 8'h88 : 8'h81);
    chk("abort_state", {remain, water}, {8'h00, therm(wc)});
    seen_spin = 1'b0;
    seen_pause = st_light[6];
    for (int j = 0; j < wc * TD; j++) begin
      if (j == wc * TD - 1) chk("drain_busy", busy, 1'b1);
      step();
      if (st_light[4]) seen_spin = 1'b1;
      if (st_light[6]) seen_pause = 1'b1;
    end
    chk("abort_idle", {st_light, water, busy}, {8'h81, 8'h00, 1'b0});
    chk("no_spin_pause", {seen_spin, seen_pause}, 2'b00);
  endtask

  initial begin
    int m, c, ph, rem, wc, p;
    repeat (2) step();
    chk("reset", {st_light, water, remain, busy, done, buzzer, overtime},
        {8'h01, 8'h00, 8'h00, 3'b000, 8'h00});
    chk("reset3", {st_light3, busy3}, {8'h01, 1'b0});
    rst = 1'b1;
    step();

    run(1, 0, 0, 32);                    // 84-cycle program, target 4
    run(1, 26, 40, 12);                  // pause 10 cycles into WASH for 40 cycles
    run_abort(1, 36, 1'b0);              // abort in WASH with 4 levels of water
    run_abort(1, 6, 1'b1);               // abort and pause together in FILL

    for (int i = 0; i < 4; i++) begin
      m = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, prog_len(m) - 1));
      model_at(m, c, ph, rem, wc);
      if (ph == 3) c = c - target(m, NM) * TD;
      run_abort(m, c, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 6; i++) begin
      m = int'($urandom_range(0, 3));
      p = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, prog_len(m) - 1));
      run(m, p, int'($urandom_range(1, 20)), int'($urandom_range(12, 40)));
    end

    run(0, 0, 0, 1200);                  // 300 ticks in DONE: overtime saturates

    // MODES=3 instance: mode 3 is out of range, mode 0 fills to (1*8)/3 = 2 levels.
    mode3 = 2'd3;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    chk("bad_mode", {st_light3, busy3}, {8'h01, 1'b0});
    step();
    chk("bad_mode_hold", {st_light3, busy3}, {8'h01, 1'b0});
    mode3 = 2'd0;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    chk("m3_fill", st_light3, 8'h02);
    repeat (7) step();
    chk("m3_fill_end", {st_light3, water3}, {8'h02, 8'h01});
    step();
    chk("m3_wash", {st_light3, water3, remain3}, {8'h04, 8'h03, 8'h06});

    // Asynchronous reset in the middle of SPIN.
    m = int'($urandom_range(0, 3));
    mode = 2'(m);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat ((2 * target(m, NM) + WB + m * WS) * TD + 2) step();
    chk("in_spin", st_light, 8'h10);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst", {st_light, water, remain, busy, done, buzzer, overtime},
        {8'h01, 8'h00, 8'h00, 3'b000, 8'h00});
    chk("async_rst3", {st_light3, water3, remain3, busy3}, {8'h01, 8'h00, 8'h00, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) step();
    chk("no_resume", {st_light, water, remain, busy}, {8'h01, 8'h00, 8'h00, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
